// File: rtl/mult_pkg.sv
// Shared types and helpers for the radix-4 Booth multiplier: FSM states, Booth
// operand select encoding, triplet decode and iteration count.
package mult_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_MUL  = 2'b01,
      ST_DONE = 2'b10
   } state_t;

   typedef enum logic [2:0] {
      SEL_ZERO = 3'd0,
      SEL_P1   = 3'd1,
      SEL_P2   = 3'd2,
      SEL_M1   = 3'd3,
      SEL_M2   = 3'd4
   } booth_sel_t;

   // Iterations for a W-bit operand extended to W+2 bits, two bits per step.
   function automatic int ITER(input int w);
      return w / 2 + 1;
   endfunction

   function automatic booth_sel_t booth_decode(input logic [2:0] trip);
      booth_sel_t sel;
      case (trip)
         3'b001, 3'b010: sel = SEL_P1;
         3'b011:         sel = SEL_P2;
         3'b100:         sel = SEL_M2;
         3'b101, 3'b110: sel = SEL_M1;
         default:        sel = SEL_ZERO;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/booth_r4_sel.sv
// Booth triplet decode: turns {A[2i+1],A[2i],A[2i-1]} into a WIDTH+3-bit
// partial-product operand; negation is bit inversion plus o_cin.
module booth_r4_sel
   import mult_pkg::*;
#(
   parameter int WIDTH = 64
) (
   input  logic [2:0]              i_trip,
   input  logic signed [WIDTH+1:0] i_b,
   output logic [WIDTH+2:0]        o_pp,
   output logic                    o_cin
);

   logic [WIDTH+2:0] w_b1;
   logic [WIDTH+2:0] w_b2;
   booth_sel_t       w_sel;

   assign w_b1  = {i_b[WIDTH+1], i_b};
   assign w_b2  = {i_b, 1'b0};
   assign w_sel = booth_decode(i_trip);

   always_comb begin
      o_pp  = '0;
      o_cin = 1'b0;
      case (w_sel)
         SEL_P1: o_pp = w_b1;
         SEL_P2: o_pp = w_b2;
         SEL_M1: begin
            o_pp  = ~w_b1;
            o_cin = 1'b1;
         end
         SEL_M2: begin
            o_pp  = ~w_b2;
            o_cin = 1'b1;
         end
         default: begin
            o_pp  = '0;
            o_cin = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/booth_r4_mult.sv
// Sequential radix-4 Booth multiplier, signed/unsigned, 2 multiplier bits per cycle.
// Optional macro MULT_EARLY_OUT_EN: a zero operand at start finishes immediately.
module booth_r4_mult
   import mult_pkg::*;
#(
   parameter int WIDTH = 64
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 i_op_start,
   input  logic                 i_op_clear,
   input  logic                 i_is_signed,
   input  logic [WIDTH-1:0]     i_multiplier,
   input  logic [WIDTH-1:0]     i_multiplicand,
   output logic                 o_busy,
   output logic                 o_op_done,
   output logic [2*WIDTH-1:0]   o_result
);

   localparam int N     = ITER(WIDTH);
   localparam int CNT_W = $clog2(N + 1);
   localparam int EW    = WIDTH + 2;
   localparam int AW    = WIDTH + 3;

   state_t                r_state;
   state_t                w_state_nxt;
   logic                  w_load;
   logic                  w_step;
   logic                  w_clr;
   logic                  w_zero;
   logic signed [AW-1:0]  r_acc;
   logic [EW-1:0]         r_a;
   logic                  r_prev;
   logic signed [EW-1:0]  r_b;
   logic [CNT_W-1:0]      r_cnt;
   logic [2*WIDTH-1:0]    r_result;

   logic [EW-1:0]         w_a_ext;
   logic signed [EW-1:0]  w_b_ext;
   logic [AW-1:0]         w_pp;
   logic                  w_cin;
   logic signed [AW-1:0]  w_sum;
   logic signed [AW-1:0]  w_acc_nxt;
   logic [EW-1:0]         w_a_nxt;
   logic [2*WIDTH-1:0]    w_prod;
   logic                  w_last;

   assign w_a_ext = {{2{i_is_signed & i_multiplier[WIDTH-1]}}, i_multiplier};
   assign w_b_ext = {{2{i_is_signed & i_multiplicand[WIDTH-1]}}, i_multiplicand};

`ifdef MULT_EARLY_OUT_EN
   assign w_zero = (i_multiplier == '0) || (i_multiplicand == '0);
`else
   assign w_zero = 1'b0;
`endif

   booth_r4_sel #(.WIDTH(WIDTH)) u_sel (
      .i_trip (({r_a[1:0], r_prev})),
      .i_b    (r_b),
      .o_pp   (w_pp),
      .o_cin  (w_cin)
   );

   // Add, then shift {acc, A} arithmetically right by two; the product's low
   // WIDTH+2 bits end up in the A register, the rest in the accumulator.
   assign w_sum     = r_acc + w_pp + AW'(w_cin);
   assign w_acc_nxt = w_sum >>> 2;
   assign w_a_nxt   = {w_sum[1:0], r_a[EW-1:2]};
   assign w_prod    = {w_acc_nxt[WIDTH-3:0], w_a_nxt};
   assign w_last    = (r_cnt == CNT_W'(1));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= ST_IDLE;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_step      = 1'b0;
      w_clr       = 1'b0;
      case (r_state)
         ST_IDLE, ST_DONE: begin
            if (i_op_clear) begin
               w_clr       = 1'b1;
               w_state_nxt = ST_IDLE;
            end else if (i_op_start) begin
               w_load      = 1'b1;
               w_state_nxt = w_zero ? ST_DONE : ST_MUL;
            end
         end
         ST_MUL: begin
            if (i_op_clear) begin
               w_clr       = 1'b1;
               w_state_nxt = ST_IDLE;
            end else begin
               w_step = 1'b1;
               if (w_last) w_state_nxt = ST_DONE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_acc    <= '0;
         r_a      <= '0;
         r_prev   <= 1'b0;
         r_b      <= '0;
         r_cnt    <= '0;
         r_result <= '0;
      end else if (w_clr) begin
         r_result <= '0;
      end else if (w_load) begin
         r_acc    <= '0;
         r_a      <= w_a_ext;
         r_prev   <= 1'b0;
         r_b      <= w_b_ext;
         r_cnt    <= CNT_W'(N);
         r_result <= '0;
      end else if (w_step) begin
         r_acc  <= w_acc_nxt;
         r_a    <= w_a_nxt;
         r_prev <= r_a[1];
         r_cnt  <= r_cnt - 1'b1;
         if (w_last) r_result <= w_prod;
      end
   end

   assign o_busy    = (r_state == ST_MUL);
   assign o_op_done = (r_state == ST_DONE);
   assign o_result  = r_result;

endmodule
